// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase codes, lamp codes and direction constants
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    A_RED = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    B_RED = 3'd5,
    PED   = 3'd6
  } phase_e;

  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_RED = 3'b100;

  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-phase tick counter, reloads to 1 on state change, saturates
module phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          load,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAX = {CW{1'b1}};

  always_ff @(posedge clk) begin
    if (!reset)
      count <= ONE;
    else if (load)
      count <= ONE;
    else if (tick && count != MAX)
      count <= count + ONE;
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-road phase sequencer with rest, early exit, walk and preemption
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CW         = 4,
  parameter int MIN_GREEN  = 4,
  parameter int YEL_LEN    = 3,
  parameter int ALLRED_LEN = 1,
  parameter int PED_LEN    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [CW-1:0] green_a_len,
  input  logic [CW-1:0] green_b_len,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          ped_req,
  input  logic          emg_req,
  input  logic          emg_dir,
  output logic [2:0]    LightA,
  output logic [2:0]    LightB,
  output logic          walk,
  output logic [2:0]    phase
);

  localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MIN_G = CW'(MIN_GREEN);
  localparam logic [CW-1:0] YEL_L = CW'(YEL_LEN);
  localparam logic [CW-1:0] RED_L = CW'(ALLRED_LEN);
  localparam logic [CW-1:0] PED_L = CW'(PED_LEN);

  phase_e        state, next_state;
  logic          ped_pending, last_dir;
  logic [CW-1:0] count, len_a, len_b;
  logic          emg_a, emg_b;
  phase_e        emg_grn;

  phase_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .load  (next_state != state),
    .count (count)
  );

  assign len_a   = (green_a_len == '0) ? ONE : green_a_len;
  assign len_b   = (green_b_len == '0) ? ONE : green_b_len;
  assign emg_a   = emg_req && (emg_dir == DIR_A);
  assign emg_b   = emg_req && (emg_dir == DIR_B);
  assign emg_grn = (emg_dir == DIR_B) ? B_GRN : A_GRN;

  always_comb begin
    next_state = state;
    if (tick) begin
      case (state)
        A_GRN: if (emg_b || (!emg_a && ((count >= len_a && (req_b || ped_pending)) ||
                                        (count >= MIN_G && req_b && !req_a))))
                 next_state = A_YEL;
        A_YEL: if (count >= YEL_L) next_state = A_RED;
        A_RED: if (count >= RED_L)
                 next_state = emg_req ? emg_grn : (ped_pending ? PED : B_GRN);
        B_GRN: if (emg_a || (!emg_b && ((count >= len_b && (req_a || ped_pending)) ||
                                        (count >= MIN_G && req_a && !req_b))))
                 next_state = B_YEL;
        B_YEL: if (count >= YEL_L) next_state = B_RED;
        B_RED: if (count >= RED_L)
                 next_state = emg_req ? emg_grn : (ped_pending ? PED : A_GRN);
        PED:   if (count >= PED_L || emg_req)
                 next_state = emg_req ? emg_grn : ((last_dir == DIR_A) ? B_GRN : A_GRN);
        default: next_state = A_GRN;
      endcase
    end
  end

  // A walk request seen on the edge that enters PED is considered served by that walk.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= A_GRN;
      ped_pending <= 1'b0;
      last_dir    <= DIR_B;
    end else begin
      state <= next_state;
      if (next_state == PED && state != PED)
        ped_pending <= 1'b0;
      else if (ped_req && state != PED)
        ped_pending <= 1'b1;
      if (state == A_RED && next_state != A_RED)
        last_dir <= DIR_A;
      else if (state == B_RED && next_state != B_RED)
        last_dir <= DIR_B;
    end
  end

  always_comb begin
    LightA = LIGHT_RED;
    LightB = LIGHT_RED;
    walk   = 1'b0;
    case (state)
      A_GRN: LightA = LIGHT_GRN;
      A_YEL: LightA = LIGHT_YEL;
      B_GRN: LightB = LIGHT_GRN;
      B_YEL: LightB = LIGHT_YEL;
      PED:   walk   = 1'b1;
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - vector table, corner sequences and random run against a road-level model
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset, tick, req_a, req_b, ped_req, emg_req, emg_dir;
  logic [3:0] green_a_len, green_b_len;
  logic [2:0] LightA, LightB, phase;
  logic       walk;

  traffic_phase_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick),
    .green_a_len(green_a_len), .green_b_len(green_b_len),
    .req_a(req_a), .req_b(req_b), .ped_req(ped_req),
    .emg_req(emg_req), .emg_dir(emg_dir),
    .LightA(LightA), .LightB(LightB), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, ncyc = 0;

  // Road-level reference: each road owns a green, a yellow and a red phase.
  phase_e grn_of [2] = '{A_GRN, B_GRN};
  phase_e yel_of [2] = '{A_YEL, B_YEL};
  phase_e red_of [2] = '{A_RED, B_RED};
  phase_e m_st = A_GRN;
  int     m_cnt = 1, m_last = 1;
  bit     m_ped = 0;

  function automatic logic [2:0] lamp(phase_e s, int road);
    if (s == grn_of[road]) return LIGHT_GRN;
    if (s == yel_of[road]) return LIGHT_YEL;
    return LIGHT_RED;
  endfunction

  function automatic int pack(phase_e s);
    return int'({3'(s), lamp(s, 0), lamp(s, 1), (s == PED)});
  endfunction

  function automatic int dut_pack();
    return int'({phase, LightA, LightB, walk});
  endfunction

  function automatic void model_step();
    phase_e nx;
    int x, y, len[2], dir;
    bit r[2], ex, ey;
    if (!reset) begin
      m_st = A_GRN; m_cnt = 1; m_ped = 0; m_last = 1;
      return;
    end
    r[0] = req_a; r[1] = req_b;
    len[0] = (green_a_len == 0) ? 1 : int'(green_a_len);
    len[1] = (green_b_len == 0) ? 1 : int'(green_b_len);
    dir = int'(emg_dir);
    x = (m_st inside {B_GRN, B_YEL, B_RED}) ? 1 : 0;
    y = 1 - x;
    ex = emg_req && dir == x;
    ey = emg_req && dir == y;
    nx = m_st;
    if (tick) begin
      if (m_st == PED) begin
        if (m_cnt >= 6 || emg_req) nx = emg_req ? grn_of[dir] : grn_of[1 - m_last];
      end else if (m_st == grn_of[x]) begin
        if (ey || (!ex && ((m_cnt >= len[x] && (r[y] || m_ped)) ||
                           (m_cnt >= 4 && r[y] && !r[x])))) nx = yel_of[x];
      end else if (m_st == yel_of[x]) begin
        if (m_cnt >= 3) nx = red_of[x];
      end else if (m_cnt >= 1) begin
        nx = emg_req ? grn_of[dir] : (m_ped ? PED : grn_of[y]);
        m_last = x;
      end
    end
    if (nx == PED && m_st != PED) m_ped = 0;
    else if (ped_req && m_st != PED) m_ped = 1;
    if (nx != m_st) m_cnt = 1;
    else if (tick && m_cnt < 15) m_cnt++;
    m_st = nx;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    ncyc++;
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic set_in(bit rs, bit tk, bit ra, bit rb, bit pr, bit er, bit ed);
    reset = rs; tick = tk; req_a = ra; req_b = rb; ped_req = pr; emg_req = er; emg_dir = ed;
  endtask

  typedef struct {
    bit rs, tk, ra, rb, pr, er, ed;
    phase_e ph;
  } vec_t;
  vec_t tv[$];

  function automatic void add(bit rs, bit tk, bit ra, bit rb, bit pr, bit er, bit ed, phase_e ph);
    vec_t v;
    v.rs = rs; v.tk = tk; v.ra = ra; v.rb = rb; v.pr = pr; v.er = er; v.ed = ed; v.ph = ph;
    tv.push_back(v);
  endfunction

  phase_e seq[6] = '{A_GRN, A_YEL, A_RED, B_GRN, B_YEL, B_RED};
  int     dur[6] = '{8, 3, 1, 10, 3, 1};
  phase_e pat[$];
  logic [2:0] prev;
  int ylen, bad_tick;
  bit found;

  initial begin
    set_in(0, 1, 0, 0, 0, 0, 0);
    green_a_len = 4'd8; green_b_len = 4'd10;

    // Early exit, walk, preemption and tick hold, expectations worked by hand.
    add(0,1,0,1,0,0,0, A_GRN);
    for (int i = 0; i < 3; i++) add(1,1,0,1,0,0,0, A_GRN);
    add(1,1,0,1,0,0,0, A_YEL);
    add(1,1,0,1,1,0,0, A_YEL);
    add(1,1,0,1,0,0,0, A_YEL);
    add(1,1,0,1,0,0,0, A_RED);
    for (int i = 0; i < 6; i++) add(1,1,0,1,0,0,0, PED);
    add(1,1,0,1,0,0,0, B_GRN);
    add(1,1,0,1,0,0,0, B_GRN);
    add(1,1,0,1,0,1,0, B_YEL);
    add(1,1,0,1,0,1,0, B_YEL);
    add(1,1,0,1,0,1,0, B_YEL);
    add(1,1,0,1,0,1,0, B_RED);
    add(1,1,0,1,0,1,0, A_GRN);
    add(1,1,0,1,0,1,0, A_GRN);
    add(1,0,0,1,0,0,0, A_GRN);
    add(1,1,0,1,0,0,0, A_GRN);
    add(1,1,0,1,0,0,0, A_GRN);
    add(1,1,0,1,0,0,0, A_YEL);
    foreach (tv[i]) begin
      set_in(tv[i].rs, tv[i].tk, tv[i].ra, tv[i].rb, tv[i].pr, tv[i].er, tv[i].ed);
      cyc();
      chk($sformatf("vec%0d", i), dut_pack(), pack(tv[i].ph));
    end

    // Rest in green with no demand, then immediate exit once B calls.
    set_in(0,1,0,0,0,0,0); cyc();
    reset = 1;
    for (int i = 0; i < 50; i++) cyc();
    chk("rest_50", dut_pack(), pack(A_GRN));
    req_b = 1; cyc();
    chk("rest_exit", dut_pack(), pack(A_YEL));

    // Full alternation: 26-cycle period with both roads calling.
    for (int s = 0; s < 6; s++) for (int d = 0; d < dur[s]; d++) pat.push_back(seq[s]);
    set_in(0,1,1,1,0,0,0); cyc();
    reset = 1;
    chk("cycle0", dut_pack(), pack(pat[0]));
    for (int k = 1; k < 53; k++) begin
      cyc();
      chk($sformatf("cycle%0d", k), dut_pack(), pack(pat[k % 26]));
    end

    // Reset asserted mid-yellow with the timebase stopped.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      found = (phase == 3'(B_YEL));
    end
    chk("reach_b_yel", int'(found), 1);
    set_in(0,0,1,1,0,0,0); cyc();
    chk("reset_edge1", dut_pack(), pack(A_GRN));
    cyc();
    chk("reset_edge2", dut_pack(), pack(A_GRN));

    // Sparse timebase: one tick in four.
    reset = 1; tick = 0; bad_tick = 0; found = 0; ylen = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick = (ncyc % 4 == 0); prev = phase; cyc();
      if (!tick && phase != prev) bad_tick++;
      found = (phase == 3'(A_YEL));
    end
    chk("reach_a_yel", int'(found), 1);
    ylen = 1;
    for (int i = 0; i < 60; i++) begin
      tick = (ncyc % 4 == 0); prev = phase; cyc();
      if (!tick && phase != prev) bad_tick++;
      if (phase != 3'(A_YEL)) break;
      ylen++;
    end
    chk("yel_span", ylen, 12);
    chk("no_idle_move", bad_tick, 0);

    // Randomised traffic against the model.
    set_in(0,1,0,0,0,0,0); cyc();
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) != 0);
      tick  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) req_a = ~req_a;
      if ($urandom_range(0, 7) == 0) req_b = ~req_b;
      ped_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) emg_req = ~emg_req;
      if ($urandom_range(0, 29) == 0) emg_dir = ~emg_dir;
      if ($urandom_range(0, 49) == 0) green_a_len = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) green_b_len = 4'($urandom_range(0, 15));
      cyc();
      if (dut_pack() !== pack(m_st) || failures < 20)
        chk($sformatf("rand%0d", i), dut_pack(), pack(m_st));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Sequences a two-road intersection (roads A and B) through green, yellow and all-red phases. Green lengths are programmable and change per direction. The block adds demand-responsive behaviour: it rests in green when the other road has no demand, and it ends a green early once the minimum green has elapsed and no car waits on the green road. It also serves a pedestrian walk phase and an emergency-vehicle preemption. It sits between the sensor/button front end and the lamp drivers.

## Interface
- CW, 4: phase counter width; counter saturates at 2^CW-1.
- MIN_GREEN, 4: minimum green ticks before early exit.
- YEL_LEN, 3: yellow ticks.
- ALLRED_LEN, 1: all-red clearance ticks.
- PED_LEN, 6: walk ticks.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- tick  in  1  timebase enable; counter and transitions advance only when tick=1.
- green_a_len  in  CW  A green length in ticks; 0 is treated as 1; compared live.
- green_b_len  in  CW  B green length in ticks; same rules as green_a_len.
- req_a, req_b  in  1  vehicle-present level, per road.
- ped_req  in  1  pedestrian button; any-cycle pulse.
- emg_req  in  1  emergency preemption level.
- emg_dir  in  1  emergency direction: 0=A, 1=B.
- LightA, LightB  out  3  lamp code: 001 green, 010 yellow, 100 red.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state code.

## Operation
- States: A_GRN, A_YEL, A_RED, B_GRN, B_YEL, B_RED, PED.
- Lamp outputs by state:
  - A_GRN: A=001, B=100.
  - A_YEL: A=010, B=100.
  - B_GRN: A=100, B=001.
  - B_YEL: A=100, B=010.
  - A_RED, B_RED, PED: both 100.
- walk=1 only in PED.
- Outputs are Moore-decoded from the state register.
- Counter starts at 1 on entry to any state. It increments on tick and saturates at 2^CW-1. Every exit test uses the current count and requires tick=1.
- Terms: emgX means emg_req=1 and emg_dir selects X; Y is the other road.
- X_GRN exits to X_YEL on any of the following:
  - emgY.
  - not emgX, count>=lenX, and (reqY or ped_pending).
  - not emgX, count>=MIN_GREEN, reqY=1 and reqX=0 (early exit).
- X_GRN with no exit condition holds indefinitely.
- X_YEL exits to X_RED when count>=YEL_LEN.
- X_RED exits when count>=ALLRED_LEN. Targets are checked in priority order:
  - emg_req=1: go to the emg_dir green (may re-enter X_GRN).
  - ped_pending=1: go to PED.
  - otherwise: go to Y_GRN.
- PED exits when count>=PED_LEN or emg_req=1. Target is the emg_dir green if emg_req=1, else the green of the road opposite last_dir.
- last_dir records the road whose RED state was just left.
- ped_pending:
  - Set by ped_req in any state except PED; ped_req during PED is ignored.
  - Cleared on entry to PED.
  - Held through emergency service.

## Timing
- Reset: reset=0 at a rising edge forces, on that edge, regardless of tick or current state:
  - state A_GRN, count=1, ped_pending=0, last_dir=B.
  - LightA=001, LightB=100, walk=0.
- With tick=1 every cycle, each phase lasts exactly its length in cycles. Outputs change on the edge after the final tick.
- ped_req, req, and emg inputs are sampled at clk. A ped_req pulse is latched on the same edge it is sampled.
- Simultaneous events:
  - Emergency outranks pedestrian, which outranks normal alternation.
  - A ped_req arriving on the same edge that X_RED exits is latched, but does not divert that exit.
- Changing a green length mid-green takes effect on the next tick's compare. If count already exceeds the new length, the exit is immediate on that tick.
- There is never a green on both roads. Green only follows a RED state or PED.

## Structure
- Shared package traffic_pkg holds:
  - the state enumeration (3-bit codes);
  - lamp constants LIGHT_GRN=3'b001, LIGHT_YEL=3'b010, LIGHT_RED=3'b100;
  - direction constants DIR_A=0, DIR_B=1.
- Sub-module phase_timer (CW): holds the counter with tick enable, synchronous load-to-1 on state change, and saturation.
- Next-state logic, ped_pending, last_dir and output decode stay in the top level.

## Test plan
- Reset: hold reset=0 for 2 cycles mid-B_YEL with tick=0. Required: LightA=001, LightB=100, walk=0, phase=A_GRN on the first edge.
- Normal cycle: tick=1, lens 8/10, req_a=req_b=1. Required: A green 8, yellow 3, red 1, B green 10, yellow 3, red 1; period 26 cycles, repeated.
- Rest and early exit:
  - req_a=req_b=0: A_GRN holds for 50 cycles.
  - Then req_b=1: A_YEL on the next edge.
  - From reset with req_a=0, req_b=1: A_YEL after 4 green cycles.
- Pedestrian: req_b=1, pulse ped_req at cycle 2. Required: after A_RED, PED for 6 cycles (walk=1, both 100), then B_GRN; ped_pending=0.
- Emergency: emg_req=1, emg_dir=1 at A_GRN count 2. Required:
  - A_YEL on the next edge, then A_RED, then B_GRN.
  - B_GRN held while emg_req=1, with req_a=1.
  - A ped pulse during hold is served after the emergency releases.
- Tick gating: tick high every 4th cycle. Required: yellow spans 12 cycles; no transition on a tick=0 cycle.
